// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared widths and the in-flight branch record used by the
//            branch history unit and its in-flight queue.
// Contents : PC_W, HIST_W, ENTRIES, IDX_W, Q_DEPTH, inflight_t
// Revision : 1.0  initial release
// ============================================================================
package bp_pkg;

    localparam int PC_W    = 10;
    localparam int HIST_W  = 3;
    localparam int ENTRIES = 8;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int Q_DEPTH = 4;

    // One predicted-but-unresolved branch. hist is the history that was
    // handed to the prediction tables at fetch; idx is the tag-table entry
    // the branch was bound to (hit or freshly allocated).
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] hist;
        logic [IDX_W-1:0]  idx;
        logic              hit;
    } inflight_t;

endpackage
`default_nettype wire

// File: rtl/bhu_inflight_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bhu_inflight_fifo
// Purpose  : Synchronous FIFO of in-flight branch records.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_push, i_data  - enqueue request and record
//            i_pop           - dequeue request (head consumed)
//            i_clear         - discard all entries
//            o_head          - record at the head (valid when !o_empty)
//            o_full, o_empty - occupancy flags
// Notes    : A push while full is accepted when a pop happens in the same
//            cycle. DEPTH must be a power of two (pointers wrap naturally).
// Revision : 1.0  initial release
// ============================================================================
module bhu_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  logic      i_clear,
    input  inflight_t i_data,
    output inflight_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    inflight_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty && !i_clear;
    assign w_do_push = i_push && (!o_full || (i_pop && !o_empty)) && !i_clear;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_history_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_history_unit
// Purpose  : Branch predictor front end. Fully-associative PC tag table with
//            a per-entry local history, lookup at fetch, an in-flight queue
//            of predictions and in-order resolution driving the prediction
//            table write port and the eviction strobe.
// Ports    : clk, rst                          - clock, sync active-high reset
//            fetch_valid/fetch_is_branch/fetch_pc - fetch slot
//            fetch_ready                       - a branch may be accepted
//            prev_history, lookup_hit          - combinational lookup result
//            resolve_valid, resolve_taken      - oldest branch resolved
//            flush                             - squash in-flight branches
//            we, branch_taken, old_pc,
//            update_history, update_valid      - registered table write port
//            evict, evict_idx                  - registered replacement strobe
//            resolve_error                     - sticky empty-queue resolve
// Revision : 1.0  initial release
// ============================================================================
module branch_history_unit #(
    parameter int ENTRIES = bp_pkg::ENTRIES,
    parameter int HIST_W  = bp_pkg::HIST_W,
    parameter int PC_W    = bp_pkg::PC_W,
    parameter int Q_DEPTH = bp_pkg::Q_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic                       fetch_is_branch,
    input  logic [PC_W-1:0]            fetch_pc,
    output logic                       fetch_ready,
    output logic [HIST_W-1:0]          prev_history,
    output logic                       lookup_hit,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic                       flush,
    output logic                       we,
    output logic                       branch_taken,
    output logic [PC_W-1:0]            old_pc,
    output logic [HIST_W-1:0]          update_history,
    output logic                       update_valid,
    output logic                       evict,
    output logic [$clog2(ENTRIES)-1:0] evict_idx,
    output logic                       resolve_error
);

    localparam int IDX_W = $clog2(ENTRIES);

    // ---------------------------------------------------------------- state
    logic [ENTRIES-1:0]  r_valid;
    logic [PC_W-1:0]     r_tag  [ENTRIES];
    logic [HIST_W-1:0]   r_hist [ENTRIES];
    logic [IDX_W-1:0]    r_rr_ptr;

    logic                r_we;
    logic                r_branch_taken;
    logic [PC_W-1:0]     r_old_pc;
    logic [HIST_W-1:0]   r_update_history;
    logic                r_update_valid;
    logic                r_evict;
    logic [IDX_W-1:0]    r_evict_idx;
    logic                r_resolve_error;

    // ---------------------------------------------------------------- wires
    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [HIST_W-1:0]   w_hit_hist;
    logic                w_has_free;
    logic [IDX_W-1:0]    w_free_idx;
    logic [IDX_W-1:0]    w_alloc_idx;
    logic                w_alloc;
    logic                w_replace;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_head_match;
    bp_pkg::inflight_t   w_push_rec;
    bp_pkg::inflight_t   w_head;

    // Tag lookup. Allocation guarantees a PC occupies at most one entry,
    // so the last match found is the only match.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_hist = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_tag[i] == fetch_pc)) begin
                w_hit      = 1'b1;
                w_hit_idx  = IDX_W'(i);
                w_hit_hist = r_hist[i];
            end
        end
    end

    // Lowest-index invalid entry: scanning downward leaves the lowest.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign lookup_hit   = w_hit;
    assign prev_history = w_hit_hist;

    // A same-cycle resolve frees a slot, so a full queue can still accept.
    assign fetch_ready = !w_full || resolve_valid;

    assign w_push      = fetch_valid && fetch_is_branch && fetch_ready && !flush;
    assign w_pop       = resolve_valid && !w_empty;
    assign w_alloc     = w_push && !w_hit;
    assign w_alloc_idx = w_has_free ? w_free_idx : r_rr_ptr;
    assign w_replace   = w_alloc && !w_has_free;

    // Snapshot taken before any same-cycle history update lands.
    always_comb begin
        w_push_rec      = '0;
        w_push_rec.pc   = fetch_pc;
        w_push_rec.hist = w_hit ? w_hit_hist : '0;
        w_push_rec.idx  = w_hit ? w_hit_idx : w_alloc_idx;
        w_push_rec.hit  = w_hit;
    end

    // The entry may have been reallocated to another PC since the branch
    // was predicted; only train it if it still belongs to that PC.
    assign w_head_match = r_valid[w_head.idx] && (r_tag[w_head.idx] == w_head.pc);

    bhu_inflight_fifo #(
        .DEPTH   (Q_DEPTH)
    ) u_inflight_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (flush),
        .i_data  (w_push_rec),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Tag table. The allocation write is placed after the history shift so
    // that, when both target the same entry, the allocation wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]  <= '0;
                r_hist[i] <= '0;
            end
        end else begin
            if (w_pop && w_head_match) begin
                r_hist[w_head.idx] <= {r_hist[w_head.idx][HIST_W-2:0], resolve_taken};
            end
            if (w_alloc) begin
                r_valid[w_alloc_idx] <= 1'b1;
                r_tag[w_alloc_idx]   <= fetch_pc;
                r_hist[w_alloc_idx]  <= '0;
            end
            if (w_replace) begin
                r_rr_ptr <= (r_rr_ptr == IDX_W'(ENTRIES - 1)) ? '0 : r_rr_ptr + 1'b1;
            end
        end
    end

    // Registered write port, eviction strobe and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we             <= 1'b0;
            r_branch_taken   <= 1'b0;
            r_old_pc         <= '0;
            r_update_history <= '0;
            r_update_valid   <= 1'b0;
            r_evict          <= 1'b0;
            r_evict_idx      <= '0;
            r_resolve_error  <= 1'b0;
        end else begin
            r_we    <= w_pop;
            r_evict <= w_replace;
            if (w_pop) begin
                r_branch_taken   <= resolve_taken;
                r_old_pc         <= w_head.pc;
                r_update_history <= w_head.hist;
                r_update_valid   <= w_head.hit;
            end
            if (w_replace) begin
                r_evict_idx <= w_alloc_idx;
            end
            if (resolve_valid && w_empty) begin
                r_resolve_error <= 1'b1;
            end
        end
    end

    assign we             = r_we;
    assign branch_taken   = r_branch_taken;
    assign old_pc         = r_old_pc;
    assign update_history = r_update_history;
    assign update_valid   = r_update_valid;
    assign evict          = r_evict;
    assign evict_idx      = r_evict_idx;
    assign resolve_error  = r_resolve_error;

endmodule
`default_nettype wire
